ram_sp_ctrl: RTL
================

// Module: ram_sp_ctrl
// PURPOSE
//   Request-side controller that sits directly upstream of the single-port synchronous RAM (ram_sp_sr_sw).
//   Converts a valid/ready request stream (read or write) into RAM cs/we/oe/address strobes.
//   Owns the shared tri-state data bus. Returns read data on a one-cycle rsp_valid pulse.
//   No bus contention: it never drives ram_data while the RAM may drive it.
// PARAMETERS
//   DATA_WIDTH  8  RAM word width; must match the attached RAM
//   ADDR_WIDTH  8  RAM address width; must match the attached RAM
// PORTS
//   clk          in     1           single clock; every register updates on posedge clk
//   reset        in     1           synchronous, active-high reset
//   req_valid    in     1           request present
//   req_ready    out    1           controller can accept a request this cycle
//   req_we       in     1           1 = write request, 0 = read request
//   req_addr     in     ADDR_WIDTH  request address
//   req_wdata    in     DATA_WIDTH  write data; ignored for reads
//   rsp_valid    out    1           one-cycle pulse; rsp_rdata is valid
//   rsp_rdata    out    DATA_WIDTH  read data
//   ram_address  out    ADDR_WIDTH  to RAM address
//   ram_cs       out    1           to RAM cs
//   ram_we       out    1           to RAM we
//   ram_oe       out    1           to RAM oe
//   ram_data     inout  DATA_WIDTH  shared RAM data bus
// BEHAVIOUR
//   Reset values:
//     - state=IDLE; ram_cs=ram_we=ram_oe=0; ram_address=0; rsp_valid=0; rsp_rdata=0.
//     - ram_data released (high-Z).
//   Registering:
//     - All ram_* strobes/address and rsp_* outputs are registered.
//     - req_ready = (state==IDLE) and is decoded from state only.
//   Handshake:
//     - A request is accepted on a posedge where req_valid && req_ready.
//     - addr, we and wdata are captured at acceptance.
//     - req_* values are don't-care while req_ready=0.
//   FSM states: IDLE, WR, RD, RD_WAIT.
//     IDLE    -> WR if accepted and req_we; -> RD if accepted and !req_we; else stay.
//     WR      1 cycle: cs=1, we=1, oe=0; ram_data driven with captured wdata. -> IDLE.
//     RD      1 cycle: cs=1, we=0, oe=1; bus released. RAM registers data_out at the cycle-end edge. -> RD_WAIT.
//     RD_WAIT 1 cycle: cs=1, we=0, oe=1 held, so the RAM drives the bus.
//             At the cycle-end edge: rsp_rdata <= ram_data; rsp_valid <= 1. -> IDLE.
//   Timing:
//     - Bus drive enable = (state==WR) only; ram_data = z in every other state.
//     - Read latency: accept at edge N -> rsp_valid high during cycle N+2..N+3 (exactly 1 cycle).
//     - Write occupancy: 2 cycles per request. Read occupancy: 3 cycles per request.
//     - Maximum rates: write 1 per 2 cycles; read 1 per 3 cycles.
//     - Back-to-back requests: req_ready returns high the cycle after WR/RD_WAIT.
//   Boundary conditions:
//     - No response backpressure; rsp_valid is a pulse and the consumer must take it.
//     - Write followed by read to the same address returns the new data (the write completes in WR before RD).
//     - Address wrap: none; the address is passed through unmodified, and all 2^ADDR_WIDTH addresses are legal.
//     - rsp_rdata holds its last value when rsp_valid=0.
//     - Reset asserted mid-operation: next edge goes to IDLE with all reset values.
//       Any in-flight read produces no rsp_valid. An in-flight write may or may not have landed.
//     - An X/Z on ram_data outside RD_WAIT must not propagate into rsp_rdata.
// STRUCTURE
//   - Shared package ram_sp_pkg: state enum/localparams (IDLE=2'd0, WR=2'd1, RD=2'd2, RD_WAIT=2'd3).
//     Also bus-release constant {DATA_WIDTH{1'bz}}.
//   - Flat module; no sub-module needed. The tri-state driver is a single continuous assign.
//   - Integration top instantiates ram_sp_ctrl and ram_sp_sr_sw with matching parameters.
// TESTING (bench: ram_sp_ctrl + real ram_sp_sr_sw, DATA_WIDTH=8, ADDR_WIDTH=8)
//   1. Hold reset 3 cycles, then release:
//      -> cs/we/oe=0, rsp_valid=0, req_ready=1, ram_data=z.
//   2. Write addr 0x12 data 0xA5, then read addr 0x12:
//      -> rsp_rdata=0xA5, rsp_valid pulses exactly 2 cycles after read acceptance.
//   3. Writes 0x00<-0x01 and 0xFF<-0xFE, then read both:
//      -> responses 0x01, 0xFE, in order.
//   4. req_valid held high with alternating W/R to addr 0x40 (data 0x33, 0x34):
//      -> req_ready low in WR/RD/RD_WAIT; reads return the last write; no request is lost or duplicated.
//   5. Assert reset during RD_WAIT of a read to 0x12:
//      -> no rsp_valid; state IDLE; a later read of 0x12 returns 0xA5.
//   6. Contention check over all tests:
//      -> ram_data never multiply driven (no X on the bus while cs=1).

Source files
------------

// File: rtl/ram_sp_pkg.sv
// ram_sp_pkg
//   Shared definitions for the single-port RAM request controller and its RAM.
//   Holds the controller FSM state encoding and the bus-release constant used
//   to release the shared tri-state data bus.
//   No ports (package).

package ram_sp_pkg;

  typedef logic [1:0] state_t;

  localparam state_t IDLE    = 2'd0;
  localparam state_t WR      = 2'd1;
  localparam state_t RD      = 2'd2;
  localparam state_t RD_WAIT = 2'd3;

  // Wide enough for any supported data width; users slice the low bits.
  localparam int          MAX_DATA_WIDTH = 64;
  localparam logic [63:0] BUS_RELEASE    = {MAX_DATA_WIDTH{1'bz}};

endpackage

// File: rtl/ram_sp_sr_sw.sv
// ram_sp_sr_sw
//   Single-port synchronous RAM, synchronous read / synchronous write, with a
//   shared bidirectional data bus.
// Ports:
//   clk      in     1           clock
//   address  in     ADDR_WIDTH  word address
//   data     inout  DATA_WIDTH  shared data bus
//   cs       in     1           chip select
//   we       in     1           write enable (1 = write)
//   oe       in     1           output enable for reads

module ram_sp_sr_sw #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 8
) (
  input  logic                  clk,
  input  logic [ADDR_WIDTH-1:0] address,
  inout  wire  [DATA_WIDTH-1:0] data,
  input  logic                  cs,
  input  logic                  we,
  input  logic                  oe
);
  import ram_sp_pkg::*;

  localparam int DEPTH = 1 << ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] mem [0:DEPTH-1];
  logic [DATA_WIDTH-1:0] data_out_q;

  // Writes land at the end of a write cycle; reads register the addressed
  // word so it appears on the bus in the following cycle.
  always_ff @(posedge clk) begin
    if (cs && we) begin
      mem[address] <= data;
    end
    if (cs && !we && oe) begin
      data_out_q <= mem[address];
    end
  end

  assign data = (cs && oe && !we) ? data_out_q : BUS_RELEASE[DATA_WIDTH-1:0];

endmodule

// File: rtl/ram_sp_ctrl.sv
// ram_sp_ctrl
//   Request-side controller for the single-port synchronous RAM. Turns a
//   valid/ready read/write request stream into registered RAM strobes, owns
//   the shared data bus during writes only, and returns read data on a
//   one-cycle rsp_valid pulse.
// Ports:
//   clk          in     1           clock
//   reset        in     1           synchronous active-high reset
//   req_valid    in     1           request present
//   req_ready    out    1           request can be accepted (state IDLE)
//   req_we       in     1           1 = write, 0 = read
//   req_addr     in     ADDR_WIDTH  request address
//   req_wdata    in     DATA_WIDTH  write data
//   rsp_valid    out    1           one-cycle read-data pulse
//   rsp_rdata    out    DATA_WIDTH  read data, held between pulses
//   ram_address  out    ADDR_WIDTH  RAM address
//   ram_cs       out    1           RAM chip select
//   ram_we       out    1           RAM write enable
//   ram_oe       out    1           RAM output enable
//   ram_data     inout  DATA_WIDTH  shared RAM data bus

module ram_sp_ctrl #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_we,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  output logic                  rsp_valid,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic [ADDR_WIDTH-1:0] ram_address,
  output logic                  ram_cs,
  output logic                  ram_we,
  output logic                  ram_oe,
  inout  wire  [DATA_WIDTH-1:0] ram_data
);
  import ram_sp_pkg::*;

  state_t                state_q, state_d;
  logic                  cs_q, cs_d;
  logic                  we_q, we_d;
  logic                  oe_q, oe_d;
  logic [ADDR_WIDTH-1:0] address_q, address_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic                  rsp_valid_q, rsp_valid_d;
  logic [DATA_WIDTH-1:0] rsp_rdata_q, rsp_rdata_d;
  logic                  accept;

  assign req_ready = (state_q == IDLE);
  assign accept    = req_valid && req_ready;

  // Next-state logic. Every non-IDLE state lasts exactly one cycle.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = req_we ? WR : RD;
      WR:      state_d = IDLE;
      RD:      state_d = RD_WAIT;
      RD_WAIT: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Strobes are derived from the next state so the registered outputs line
  // up with the state they belong to. oe stays high through RD_WAIT so the
  // RAM keeps driving its registered word while it is sampled.
  always_comb begin
    cs_d        = (state_d != IDLE);
    we_d        = (state_d == WR);
    oe_d        = (state_d == RD) || (state_d == RD_WAIT);
    address_d   = accept ? req_addr  : address_q;
    wdata_d     = accept ? req_wdata : wdata_q;
    rsp_valid_d = (state_q == RD_WAIT);
    // Only sample the bus in RD_WAIT so an X/Z elsewhere cannot leak in.
    rsp_rdata_d = (state_q == RD_WAIT) ? ram_data : rsp_rdata_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      cs_q        <= 1'b0;
      we_q        <= 1'b0;
      oe_q        <= 1'b0;
      address_q   <= '0;
      wdata_q     <= '0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
    end else begin
      state_q     <= state_d;
      cs_q        <= cs_d;
      we_q        <= we_d;
      oe_q        <= oe_d;
      address_q   <= address_d;
      wdata_q     <= wdata_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
    end
  end

  assign ram_cs      = cs_q;
  assign ram_we      = we_q;
  assign ram_oe      = oe_q;
  assign ram_address = address_q;
  assign rsp_valid   = rsp_valid_q;
  assign rsp_rdata   = rsp_rdata_q;

  // Drive the bus only in WR; the RAM owns it in RD/RD_WAIT.
  assign ram_data = (state_q == WR) ? wdata_q : BUS_RELEASE[DATA_WIDTH-1:0];

endmodule
